// File: rtl/wb_write_queue.sv
// In-order writeback queue in front of the 16x16 register file write port.
// Accepts up to two requests per cycle (mem older than alu), drains one per cycle, and bypasses pending values to both read ports.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [3:0]    mem_reg,
    input  logic [15:0]   mem_data,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [3:0]    alu_reg,
    input  logic [15:0]   alu_data,
    output logic          alu_ready,
    input  logic          wb_hold,
    output logic [3:0]    DstReg,
    output logic          WriteReg,
    output logic [15:0]   DstData,
    input  logic [3:0]    SrcReg1,
    input  logic [3:0]    SrcReg2,
    output logic          byp_hit1,
    output logic [15:0]   byp_data1,
    output logic          byp_hit2,
    output logic [15:0]   byp_data2,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [3:0]       reg_q  [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    alu_idx;
    logic [AW:0]      count_q;
    logic [AW:0]      free;
    logic [AW:0]      enq_n;
    logic [AW:0]      deq_n;
    logic             mem_enq;
    logic             alu_enq;
    logic             deq;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // Readiness looks only at the registered occupancy; a drain in the same cycle does not free a slot early.
    assign free      = (AW+1)'(DEPTH) - count_q;
    assign mem_ready = (free >= (AW+1)'(1));
    assign alu_ready = (free >= (AW+1)'(2)) | ((free >= (AW+1)'(1)) & ~mem_valid);

    // Writes to R0 complete the handshake but never occupy a slot.
    assign mem_enq = mem_valid & mem_ready & (mem_reg != 4'd0);
    assign alu_enq = alu_valid & alu_ready & (alu_reg != 4'd0);
    assign alu_idx = mem_enq ? wr_ptr + AW'(1) : wr_ptr;

    assign deq   = ~empty & ~wb_hold & ~rst;
    assign enq_n = (AW+1)'(mem_enq) + (AW+1)'(alu_enq);
    assign deq_n = (AW+1)'(deq);

    assign WriteReg = deq;
    assign DstReg   = empty ? 4'd0  : reg_q[rd_ptr];
    assign DstData  = empty ? 16'd0 : data_q[rd_ptr];

    // Walks oldest to youngest so the last match seen is the youngest pending value.
    function automatic logic [16:0] lookup(input logic [3:0] src);
        logic [AW-1:0] idx;
        logic          hit;
        logic [15:0]   data;
        hit  = 1'b0;
        data = 16'd0;
        idx  = '0;
        if (src != 4'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + AW'(i);
                if (vld_q[idx] && (reg_q[idx] == src)) begin
                    hit  = 1'b1;
                    data = data_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {byp_hit1, byp_data1} = lookup(SrcReg1);
        {byp_hit2, byp_data2} = lookup(SrcReg2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (mem_enq) begin
                reg_q[wr_ptr]  <= mem_reg;
                data_q[wr_ptr] <= mem_data;
                vld_q[wr_ptr]  <= 1'b1;
            end
            if (alu_enq) begin
                reg_q[alu_idx]  <= alu_reg;
                data_q[alu_idx] <= alu_data;
                vld_q[alu_idx]  <= 1'b1;
            end
            wr_ptr  <= wr_ptr + AW'(mem_enq) + AW'(alu_enq);
            count_q <= count_q + enq_n - deq_n;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: directed requests push expected register-file writes,
// a negedge monitor pops and compares every WriteReg pulse.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_reg = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_reg = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        wb_hold = 1'b0;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic        byp_hit1;
    logic [15:0] byp_data1;
    logic        byp_hit2;
    logic [15:0] byp_data2;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q [$];

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold), .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                                 input logic av, input logic [3:0] ar, input logic [15:0] ad);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic expectWrite(input logic [3:0] r, input logic [15:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (WriteReg === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", {12'd0, DstReg, DstData}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                checkOutput("write_reg",  {28'd0, DstReg}, {28'd0, e[19:16]});
                checkOutput("write_data", {16'd0, DstData}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        $display("[TB] start");
        // Reset held for two cycles
        nextCycle();
        nextCycle();
        rst = 1'b0;
        settle();
        checkOutput("rst_writereg", {31'd0, WriteReg}, 32'd0);
        checkOutput("rst_empty",    {31'd0, empty}, 32'd1);
        checkOutput("rst_full",     {31'd0, full}, 32'd0);
        checkOutput("rst_count",    {29'd0, count}, 32'd0);
        checkOutput("rst_dstreg",   {28'd0, DstReg}, 32'd0);
        checkOutput("rst_dstdata",  {16'd0, DstData}, 32'd0);
        checkOutput("rst_mem_rdy",  {31'd0, mem_ready}, 32'd1);
        checkOutput("rst_alu_rdy",  {31'd0, alu_ready}, 32'd1);
        checkOutput("rst_byp1",     {31'd0, byp_hit1}, 32'd0);

        // Single write with bypass
        nextCycle();
        applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'd0);
        expectWrite(4'd3, 16'hBEEF);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        SrcReg1 = 4'd3;
        settle();
        checkOutput("single_count", {29'd0, count}, 32'd1);
        checkOutput("single_hit",   {31'd0, byp_hit1}, 32'd1);
        checkOutput("single_bdata", {16'd0, byp_data1}, 32'h0000BEEF);
        nextCycle();
        settle();
        checkOutput("single_hit_gone", {31'd0, byp_hit1}, 32'd0);
        checkOutput("single_bdata0",   {16'd0, byp_data1}, 32'd0);
        checkOutput("single_empty",    {31'd0, empty}, 32'd1);

        // Dual enqueue: mem is older than alu, bypass returns the younger
        nextCycle();
        applyStimulus(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002);
        settle();
        checkOutput("dual_alu_rdy", {31'd0, alu_ready}, 32'd1);
        expectWrite(4'd5, 16'h0001);
        expectWrite(4'd5, 16'h0002);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        SrcReg2 = 4'd5;
        settle();
        checkOutput("dual_count", {29'd0, count}, 32'd2);
        checkOutput("dual_hit2",  {31'd0, byp_hit2}, 32'd1);
        checkOutput("dual_byp2",  {16'd0, byp_data2}, 32'h0002);
        nextCycle();
        settle();
        checkOutput("dual_byp2_last", {16'd0, byp_data2}, 32'h0002);
        nextCycle();
        settle();
        checkOutput("dual_hit2_gone", {31'd0, byp_hit2}, 32'd0);

        // Fill to capacity under hold
        wb_hold = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022);
        expectWrite(4'd1, 16'h0011);
        expectWrite(4'd2, 16'h0022);
        nextCycle();
        applyStimulus(1'b1, 4'd4, 16'h0044, 1'b1, 4'd6, 16'h0066);
        settle();
        checkOutput("fill_alu_rdy2", {31'd0, alu_ready}, 32'd1);
        expectWrite(4'd4, 16'h0044);
        expectWrite(4'd6, 16'h0066);
        nextCycle();
        applyStimulus(1'b1, 4'd7, 16'h0777, 1'b0, 4'd0, 16'd0);
        SrcReg1 = 4'd2;
        settle();
        checkOutput("full_flag",    {31'd0, full}, 32'd1);
        checkOutput("full_count",   {29'd0, count}, 32'd4);
        checkOutput("full_mem_rdy", {31'd0, mem_ready}, 32'd0);
        checkOutput("full_alu_rdy", {31'd0, alu_ready}, 32'd0);
        checkOutput("hold_nowrite", {31'd0, WriteReg}, 32'd0);
        checkOutput("hold_dstreg",  {28'd0, DstReg}, 32'd1);
        checkOutput("hold_dstdata", {16'd0, DstData}, 32'h0011);
        checkOutput("full_byp1",    {16'd0, byp_data1}, 32'h0022);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        settle();
        checkOutput("full_reject_cnt", {29'd0, count}, 32'd4);
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) nextCycle();
        settle();
        checkOutput("drain_empty", {31'd0, empty}, 32'd1);

        // Partial space: count 3 admits only the mem request
        wb_hold = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 4'd7, 16'h0007, 1'b1, 4'd8, 16'h0008);
        expectWrite(4'd7, 16'h0007);
        expectWrite(4'd8, 16'h0008);
        nextCycle();
        applyStimulus(1'b1, 4'd9, 16'h0009, 1'b0, 4'd0, 16'd0);
        expectWrite(4'd9, 16'h0009);
        nextCycle();
        applyStimulus(1'b1, 4'd10, 16'h000A, 1'b1, 4'd11, 16'h000B);
        settle();
        checkOutput("part_count",   {29'd0, count}, 32'd3);
        checkOutput("part_mem_rdy", {31'd0, mem_ready}, 32'd1);
        checkOutput("part_alu_rdy", {31'd0, alu_ready}, 32'd0);
        expectWrite(4'd10, 16'h000A);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        SrcReg2 = 4'd11;
        settle();
        checkOutput("part_count4", {29'd0, count}, 32'd4);
        checkOutput("part_no_alu", {31'd0, byp_hit2}, 32'd0);
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) nextCycle();
        settle();
        checkOutput("part_empty", {31'd0, empty}, 32'd1);

        // R0 requests are accepted and dropped
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hFFFF);
        SrcReg1 = 4'd0;
        settle();
        checkOutput("r0_alu_rdy", {31'd0, alu_ready}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        settle();
        checkOutput("r0_count", {29'd0, count}, 32'd0);
        checkOutput("r0_byp1",  {31'd0, byp_hit1}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd0, 16'h1111, 1'b1, 4'd12, 16'hC0DE);
        expectWrite(4'd12, 16'hC0DE);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        SrcReg1 = 4'd12;
        settle();
        checkOutput("r0_mix_count", {29'd0, count}, 32'd1);
        checkOutput("r0_mix_byp",   {16'd0, byp_data1}, 32'h0000C0DE);
        nextCycle();

        // Reset mid-operation drops pending entries without writing
        wb_hold = 1'b1;
        applyStimulus(1'b1, 4'd13, 16'h000D, 1'b1, 4'd14, 16'h000E);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        wb_hold = 1'b0;
        rst = 1'b1;
        settle();
        checkOutput("mid_rst_nowrite", {31'd0, WriteReg}, 32'd0);
        nextCycle();
        rst = 1'b0;
        SrcReg1 = 4'd13;
        settle();
        checkOutput("mid_rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("mid_rst_count", {29'd0, count}, 32'd0);
        checkOutput("mid_rst_byp",   {31'd0, byp_hit1}, 32'd0);
        checkOutput("mid_rst_alu",   {31'd0, alu_ready}, 32'd1);

        for (int i = 0; i < 4; i++) nextCycle();
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
